// File: rtl/sid_pkg.sv
// Shared SID bus types: register widths, the core-side bus bundle and
// the command word consumed by sid_bus_master.
package sid;

    localparam int DELAY_W_DEF   = 16;
    localparam int RES_TICKS_DEF = 10;
    localparam int CMD_DELAY_W   = DELAY_W_DEF;

    typedef logic [4:0] reg5_t;
    typedef logic [7:0] reg8_t;

    typedef struct packed {
        reg5_t addr;
        reg8_t data;
        logic  we;
        logic  oe;
        logic  res;
    } bus_i_t;

    typedef struct packed {
        logic [CMD_DELAY_W-1:0] delay;
        reg5_t                  addr;
        reg8_t                  data;
        logic                   we;
    } bus_cmd_t;

    localparam bus_i_t BUS_IDLE  = '0;
    localparam bus_i_t BUS_RESET = '{addr: '0, data: '0, we: 1'b0,
                                     oe: 1'b0, res: 1'b1};

    // Read cycles drive zero on the data lines.
    function automatic bus_i_t bus_drive(reg5_t addr, reg8_t data,
                                         logic we);
        bus_i_t b;
        b      = '0;
        b.addr = addr;
        b.data = we ? data : '0;
        b.we   = we;
        b.oe   = ~we;
        return b;
    endfunction

endpackage

// File: rtl/sid_bus_master.sv
// Paces register accesses to the SID core on phi2 boundaries and
// generates the SID reset pulse.
module sid_bus_master #(
    parameter int DELAY_W   = sid::DELAY_W_DEF,
    parameter int RES_TICKS = sid::RES_TICKS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          phi2_tick,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  sid::bus_cmd_t cmd,
    input  logic          res_req,
    output sid::bus_i_t   bus_o,
    input  sid::reg8_t    bus_data_i,
    output logic          rsp_valid,
    output sid::reg8_t    rsp_data
);

    import sid::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESET
    } state_t;

    localparam logic [DELAY_W-1:0] RES_LOAD = DELAY_W'(RES_TICKS - 1);

    state_t             state;
    logic [DELAY_W-1:0] cnt;
    reg5_t              addr_q;
    reg8_t              data_q;
    logic               we_q;
    logic               idle_q;
    logic               cnt_zero;
    logic               accept;

    // idle_q is cleared by rst, so ready only rises one edge after release.
    assign cmd_ready = idle_q & ~res_req;
    assign accept    = cmd_valid & cmd_ready;
    assign cnt_zero  = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            idle_q    <= 1'b0;
            bus_o     <= BUS_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (res_req) begin
                state  <= S_RESET;
                cnt    <= RES_LOAD;
                idle_q <= 1'b0;
                bus_o  <= BUS_RESET;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            addr_q <= cmd.addr;
                            data_q <= cmd.data;
                            we_q   <= cmd.we;
                            cnt    <= DELAY_W'(cmd.delay);
                            idle_q <= 1'b0;
                            state  <= S_WAIT;
                        end else begin
                            idle_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (phi2_tick) begin
                            if (cnt_zero) begin
                                state <= S_ACCESS;
                                bus_o <= bus_drive(addr_q, data_q, we_q);
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    S_ACCESS: begin
                        if (phi2_tick) begin
                            state  <= S_IDLE;
                            idle_q <= 1'b1;
                            bus_o  <= BUS_IDLE;
                            if (!we_q) begin
                                rsp_valid <= 1'b1;
                                rsp_data  <= bus_data_i;
                            end
                        end
                    end
                    S_RESET: begin
                        if (phi2_tick) begin
                            if (cnt_zero) begin
                                state  <= S_IDLE;
                                idle_q <= 1'b1;
                                bus_o  <= BUS_IDLE;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        idle_q <= 1'b0;
                        bus_o  <= BUS_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sid_bus_master.sv
// Bench for sid_bus_master: tick-count reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sid_bus_master;

    import sid::*;

    localparam int DW = 8;
    localparam int RT = 10;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     phi2_tick = 1'b0;
    logic     cmd_valid = 1'b0;
    logic     cmd_ready;
    bus_cmd_t cmd = '0;
    logic     res_req = 1'b0;
    bus_i_t   bus_o;
    reg8_t    bus_data_i = '0;
    logic     rsp_valid;
    reg8_t    rsp_data;

    always #5 clk = ~clk;

    sid_bus_master #(.DELAY_W(DW), .RES_TICKS(RT)) dut (
        .clk(clk), .rst(rst), .phi2_tick(phi2_tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .res_req(res_req), .bus_o(bus_o), .bus_data_i(bus_data_i),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: absolute phi2 tick count T, command access window and
    // reset window expressed as tick numbers.
    longint T = 0;
    bit     m_rdy_en = 0, m_pend = 0, m_res = 0;
    longint m_start = 0, m_res_end = 0;
    reg5_t  m_addr = '0;
    reg8_t  m_data = '0;
    bit     m_we = 0;
    bit     m_acc = 0;
    longint m_acc_T = 0;
    bit     m_rsp_v = 0;
    reg8_t  m_rsp_d = '0;
    bus_i_t m_bus;
    int     rsp_seen = 0;

    initial forever begin
        @(posedge clk);
        m_acc   = 0;
        m_rsp_v = 0;
        if (rst) begin
            m_rdy_en = 0;
            m_pend   = 0;
            m_res    = 0;
            m_rsp_d  = '0;
        end else begin
            if (phi2_tick) T++;
            if (res_req) begin
                m_pend    = 0;
                m_res     = 1;
                m_res_end = T + RT;
            end else if (m_res) begin
                if (T >= m_res_end) m_res = 0;
            end else if (m_pend) begin
                if (T == m_start + 1) begin
                    m_pend = 0;
                    if (!m_we) begin
                        m_rsp_v = 1;
                        m_rsp_d = bus_data_i;
                    end
                end
            end else if (m_rdy_en && cmd_valid) begin
                m_pend  = 1;
                m_start = T + longint'(cmd.delay) + 1;
                m_addr  = cmd.addr;
                m_data  = cmd.data;
                m_we    = cmd.we;
                m_acc   = 1;
                m_acc_T = T;
            end
            m_rdy_en = 1;
        end
        #1;
        m_bus = '0;
        if (!rst && m_res) begin
            m_bus.res = 1'b1;
        end else if (!rst && m_pend && T >= m_start) begin
            m_bus.addr = m_addr;
            m_bus.data = m_we ? m_data : 8'h00;
            m_bus.we   = m_we;
            m_bus.oe   = !m_we;
        end
        if (rsp_valid) rsp_seen++;
        chk("bus_o", bus_o, m_bus);
        chk("cmd_ready", cmd_ready,
            !rst && m_rdy_en && !m_pend && !m_res && !res_req);
        chk("rsp_valid", rsp_valid, m_rsp_v);
        chk("rsp_data", rsp_data, m_rsp_d);
    end

    int tick_per  = 20;
    int tick_ctr  = 0;
    bit rand_data = 0;

    task automatic nedge();
        @(negedge clk);
        if (tick_per > 0) begin
            phi2_tick = (tick_ctr == 0);
            tick_ctr  = (tick_ctr + 1) % tick_per;
        end else begin
            phi2_tick = ($urandom_range(2) == 0);
        end
        if (rand_data) bus_data_i = 8'($urandom);
    endtask

    task automatic idle_n(int n);
        repeat (n) nedge();
    endtask

    function automatic bus_cmd_t mk(int d, int a, int v, bit we);
        bus_cmd_t c;
        c.delay = 16'(d);
        c.addr  = 5'(a);
        c.data  = 8'(v);
        c.we    = we;
        return c;
    endfunction

    task automatic send(bus_cmd_t c);
        int n;
        cmd       = c;
        cmd_valid = 1'b1;
        n         = 0;
        do begin
            nedge();
            n++;
        end while (!m_acc && n < 3000);
        cmd_valid = 1'b0;
        chk("accept", m_acc, 1);
    endtask

    task automatic wait_access(output longint d);
        int n;
        n = 0;
        while (!(bus_o.we || bus_o.oe) && n < 2000) begin
            nedge();
            n++;
        end
        chk("access_seen", bus_o.we | bus_o.oe, 1);
        d = T - m_acc_T;
    endtask

    task automatic wait_res_done();
        int n;
        n = 0;
        while (bus_o.res && n < 2000) begin
            nedge();
            n++;
        end
        chk("res_done", bus_o.res, 0);
    endtask

    longint d, t0;
    int     n, r0, seen, nacc;
    bit     pw, w;
    int     rises[$];
    int     falls[$];

    initial begin
        idle_n(3);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_bus", bus_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;
        nedge();
        chk("ready_after_rst", cmd_ready, 1);
        idle_n(5);

        // write, delay 0
        r0 = rsp_seen;
        send(mk(0, 'h18, 'h0F, 1));
        wait_access(d);
        chk("w_start_tick", d, 1);
        chk("w_addr", bus_o.addr, 'h18);
        chk("w_data", bus_o.data, 'h0F);
        chk("w_oe", bus_o.oe, 0);
        n = 0;
        while (bus_o.we && n < 100) begin
            n++;
            nedge();
        end
        chk("w_len", n, 20);
        idle_n(5);
        chk("w_no_rsp", rsp_seen - r0, 0);

        // read, delay 3
        bus_data_i = 8'hA5;
        send(mk(3, 'h1B, 'h77, 0));
        wait_access(d);
        chk("r_start_tick", d, 4);
        chk("r_addr", bus_o.addr, 'h1B);
        chk("r_data_zero", bus_o.data, 0);
        n = 0;
        while (bus_o.oe && n < 100) begin
            n++;
            nedge();
        end
        chk("r_len", n, 20);
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_data", rsp_data, 'hA5);
        nedge();
        chk("r_rsp_pulse", rsp_valid, 0);
        idle_n(5);

        // accept coincident with a tick, delay 1
        n = 0;
        do begin
            nedge();
            n++;
        end while (!phi2_tick && n < 100);
        cmd       = mk(1, 'h04, 'h3C, 1);
        cmd_valid = 1'b1;
        nedge();
        cmd_valid = 1'b0;
        chk("co_accept", m_acc, 1);
        wait_access(d);
        chk("co_start_tick", d, 2);
        idle_n(45);

        // reset request aborts a pending read
        r0 = rsp_seen;
        send(mk(100, 'h10, 0, 0));
        idle_n(60);
        res_req = 1'b1;
        nedge();
        res_req = 1'b0;
        t0 = T;
        chk("rr_res", bus_o.res, 1);
        chk("rr_weoe", {bus_o.we, bus_o.oe}, 0);
        seen = 0;
        n    = 0;
        while (bus_o.res && n < 400) begin
            if (bus_o.we || bus_o.oe) seen++;
            nedge();
            n++;
        end
        chk("rr_ticks", T - t0, 10);
        chk("rr_ready", cmd_ready, 1);
        repeat (100) begin
            if (bus_o.we || bus_o.oe) seen++;
            nedge();
        end
        chk("rr_no_access", seen, 0);
        chk("rr_no_rsp", rsp_seen - r0, 0);

        // res_req and cmd_valid together
        cmd       = mk(0, 'h01, 'h55, 1);
        cmd_valid = 1'b1;
        res_req   = 1'b1;
        nedge();
        cmd_valid = 1'b0;
        res_req   = 1'b0;
        chk("rc_res", bus_o.res, 1);
        chk("rc_ready", cmd_ready, 0);
        wait_res_done();
        seen = 0;
        repeat (60) begin
            if (bus_o.we) seen++;
            nedge();
        end
        chk("rc_not_accepted", seen, 0);

        // back-to-back writes, valid held
        cmd       = mk(0, 'h02, 'h11, 1);
        cmd_valid = 1'b1;
        nacc      = 0;
        pw        = 0;
        for (int i = 0; i < 150; i++) begin
            nedge();
            if (m_acc) begin
                nacc++;
                if (nacc == 1) cmd = mk(0, 'h03, 'h22, 1);
                else cmd_valid = 1'b0;
            end
            w = bus_o.we;
            if (w && !pw) rises.push_back(i);
            if (!w && pw) falls.push_back(i);
            pw = w;
        end
        cmd_valid = 1'b0;
        chk("bb_runs", rises.size(), 2);
        if (rises.size() >= 2 && falls.size() >= 2) begin
            chk("bb_len1", falls[0] - rises[0], 20);
            chk("bb_gap", rises[1] - falls[0], 20);
            chk("bb_len2", falls[1] - rises[1], 20);
        end
        idle_n(5);

        // top of the register map is passed through
        send(mk(0, 'h1F, 0, 0));
        wait_access(d);
        chk("hi_addr", bus_o.addr, 'h1F);
        idle_n(45);

        // maximum delay for an 8-bit counter
        tick_per = 2;
        tick_ctr = 0;
        send(mk(255, 'h07, 'h99, 1));
        wait_access(d);
        chk("max_delay_tick", d, 256);
        idle_n(10);

        // asynchronous reset during an access
        tick_per = 20;
        tick_ctr = 0;
        send(mk(0, 'h05, 'hF0, 1));
        wait_access(d);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_weoe", {bus_o.we, bus_o.oe}, 0);
        chk("async_bus", bus_o, 0);
        idle_n(2);
        rst = 1'b0;
        nedge();
        chk("ready_after_rst2", cmd_ready, 1);

        // randomized traffic
        rand_data = 1;
        for (int s = 0; s < 6; s++) begin
            tick_per = $urandom_range(0, 6);
            tick_ctr = 0;
            for (int i = 0; i < 500; i++) begin
                nedge();
                res_req = ($urandom_range(80) == 0);
                if (m_acc) cmd_valid = 1'b0;
                if (!cmd_valid && $urandom_range(2) == 0) begin
                    cmd = mk($urandom_range(0, 4), $urandom_range(0, 31),
                             $urandom_range(0, 255), 1'($urandom));
                    cmd_valid = 1'b1;
                end
            end
        end
        res_req   = 1'b0;
        cmd_valid = 1'b0;
        idle_n(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
